// File: rtl/xc_malu_pkg.sv
// Shared types and constants for the masked ALU datapath.
package xc_malu_pkg;

  typedef enum logic [1:0] {
    A2B_IDLE = 2'd0,
    A2B_LOAD = 2'd1,
    A2B_RUN  = 2'd2,
    A2B_DONE = 2'd3
  } a2b_state_e;

  localparam int unsigned XC_A2B_LATENCY = 34;
  localparam int unsigned XC_A2B_CNT_W   = 5;

endpackage

// File: rtl/xc_malu_a2b_if.sv
// Operand/result handshake bundle for the arithmetic-to-boolean converter.
interface xc_malu_a2b_if #(parameter int unsigned XL = 31);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [XL:0]   a0;
  logic [XL:0]   a1;
  logic [XL:0]   rng;
  logic          out_valid;
  logic          out_ack;
  logic [XL:0]   b0;
  logic [XL:0]   b1;

  modport master (
    output flush, in_valid, a0, a1, rng, out_ack,
    input  in_ready, out_valid, b0, b1
  );

  modport slave (
    input  flush, in_valid, a0, a1, rng, out_ack,
    output in_ready, out_valid, b0, b1
  );
endinterface

// File: rtl/xc_malu_isw_and.sv
// 1-bit, 2-share ISW AND gadget; term order is fixed to keep the masking sound.
module xc_malu_isw_and (
  input  logic x0,
  input  logic x1,
  input  logic y0,
  input  logic y1,
  input  logic r,
  output logic z0_c,
  output logic z1_c
);
  assign z0_c = (x0 & y0) ^ r;
  assign z1_c = (x1 & y1) ^ ((r ^ (x0 & y1)) ^ (x1 & y0));
endmodule

// File: rtl/xc_malu_a2b.sv
// Bit-serial masked ripple-carry adder converting arithmetic shares to boolean shares.
module xc_malu_a2b
  import xc_malu_pkg::*;
#(
  parameter int unsigned XL = 31
) (
  input  logic         g_clk,
  input  logic         g_reset,
  xc_malu_a2b_if.slave bus
);

  a2b_state_e                state;
  a2b_state_e                state_nxt;
  logic [XC_A2B_CNT_W-1:0]   cnt;
  logic [XL:0]               u0, u1, v0, v1, a1_hold;
  logic [XL:0]               b0_q, b1_q;
  logic                      c0, c1;
  logic                      in_ready_q, out_valid_q;
  logic                      s0, s1, p0, p1;
  logic                      g0, g1, t0, t1;
  logic                      last_bit;
  logic                      take;

  assign last_bit = (cnt == XC_A2B_CNT_W'(XL));
  assign take     = out_valid_q & bus.out_ack;

  // Share-wise sum and propagate; each share stays in its own lane.
  assign s0 = u0[0] ^ v0[0] ^ c0;
  assign s1 = u1[0] ^ v1[0] ^ c1;
  assign p0 = u0[0] ^ v0[0];
  assign p1 = u1[0] ^ v1[0];

  xc_malu_isw_and u_and_g (
    .x0(u0[0]), .x1(u1[0]), .y0(v0[0]), .y1(v1[0]), .r(bus.rng[0]),
    .z0_c(g0), .z1_c(g1)
  );

  xc_malu_isw_and u_and_t (
    .x0(c0), .x1(c1), .y0(p0), .y1(p1), .r(bus.rng[1]),
    .z0_c(t0), .z1_c(t1)
  );

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state <= A2B_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      A2B_IDLE: if (bus.in_valid) state_nxt = A2B_LOAD;
      A2B_LOAD: state_nxt = A2B_RUN;
      A2B_RUN:  if (last_bit) state_nxt = A2B_DONE;
      A2B_DONE: if (take) state_nxt = A2B_IDLE;
      default:  state_nxt = A2B_IDLE;
    endcase
    if (bus.flush) state_nxt = A2B_IDLE;
  end

  // Datapath: a1 is masked one cycle after acceptance and its holding copy wiped.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      cnt         <= '0;
      u0          <= '0;
      u1          <= '0;
      v0          <= '0;
      v1          <= '0;
      a1_hold     <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      c0          <= 1'b0;
      c1          <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_nxt == A2B_IDLE);
      out_valid_q <= ~bus.flush & (state == A2B_DONE) & ~take;
      if (bus.flush) begin
        cnt     <= '0;
        u0      <= '0;
        u1      <= '0;
        v0      <= '0;
        v1      <= '0;
        a1_hold <= '0;
        b0_q    <= '0;
        b1_q    <= '0;
        c0      <= 1'b0;
        c1      <= 1'b0;
      end else begin
        case (state)
          A2B_IDLE: if (bus.in_valid) begin
            u0      <= bus.a0 ^ bus.rng;
            u1      <= bus.rng;
            a1_hold <= bus.a1;
          end
          A2B_LOAD: begin
            v0      <= a1_hold ^ bus.rng;
            v1      <= bus.rng;
            a1_hold <= '0;
            c0      <= 1'b0;
            c1      <= 1'b0;
            cnt     <= '0;
          end
          A2B_RUN: begin
            b0_q <= {s0, b0_q[XL:1]};
            b1_q <= {s1, b1_q[XL:1]};
            u0   <= {1'b0, u0[XL:1]};
            u1   <= {1'b0, u1[XL:1]};
            v0   <= {1'b0, v0[XL:1]};
            v1   <= {1'b0, v1[XL:1]};
            c0   <= g0 ^ t0;
            c1   <= g1 ^ t1;
            if (!last_bit) cnt <= cnt + XC_A2B_CNT_W'(1);
          end
          A2B_DONE: if (take) begin
            cnt  <= '0;
            u0   <= '0;
            u1   <= '0;
            v0   <= '0;
            v1   <= '0;
            b0_q <= '0;
            b1_q <= '0;
            c0   <= 1'b0;
            c1   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.b0        = b0_q;
  assign bus.b1        = b1_q;

endmodule

// File: tb/tb_xc_malu_a2b.sv
// Directed bench for the arithmetic-to-boolean converter.
module tb_xc_malu_a2b;
  import xc_malu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic        rand_rng;
  logic [31:0] rng_const;

  xc_malu_a2b_if #(.XL(31)) bus ();

  xc_malu_a2b #(.XL(31)) dut (
    .g_clk  (clk),
    .g_reset(rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.rng = rand_rng ? $urandom : rng_const;
  endtask

  task automatic start_op(input logic [31:0] x0, input logic [31:0] x1);
    int n;
    bus.a0 = x0;
    bus.a1 = x1;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.a0 = '0;
    bus.a1 = '0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack();
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_b0"}, bus.b0, 32'd0);
    chk({tag, "_b1"}, bus.b1, 32'd0);
  endtask

  task automatic full_op(input string tag, input logic [31:0] x0, input logic [31:0] x1);
    int lat;
    start_op(x0, x1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(XC_A2B_LATENCY));
    chk({tag, "_sum"}, bus.b0 ^ bus.b1, x0 + x1);
    ack();
  endtask

  initial begin
    int          lat;
    logic [31:0] hb0, hb1;
    logic [31:0] ra, rb;

    rst = 1'b1;
    rand_rng = 1'b0;
    rng_const = 32'h0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.a0 = '0;
    bus.a1 = '0;
    bus.rng = '0;
    bus.out_ack = 1'b0;
    #12;
    check_idle("reset");
    chk("reset_cnt", 32'(dut.cnt), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(A2B_IDLE));
    rst = 1'b0;
    tick();

    // Zero randomness: share 1 stays all-zero.
    start_op(32'h5, 32'h3);
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    wait_done(lat);
    chk("zero_lat", 32'(lat), 32'd34);
    chk("zero_b0", bus.b0, 32'h8);
    chk("zero_b1", bus.b1, 32'h0);
    ack();
    check_idle("zero_ack");

    // Wrap-around and full carry chain.
    rand_rng = 1'b1;
    full_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001);
    rand_rng = 1'b0;
    rng_const = 32'hA5A5_A5A5;
    bus.rng = rng_const;
    full_op("chain", 32'h7FFF_FFFF, 32'h0000_0001);
    rand_rng = 1'b1;

    // Flush in RUN cycle 10, then a fresh op straight away.
    start_op(32'h1234_5678, 32'h1111_1111);
    tick();
    repeat (10) tick();
    chk("flush_pre_state", 32'(dut.state), 32'(A2B_RUN));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_idle("flush");
    full_op("after_flush", 32'hDEAD_BEEF, 32'h0BAD_F00D);

    // Held output while in_valid is raised; nothing new may be accepted.
    start_op(32'h0F0F_0F0F, 32'hF0F0_F0F1);
    wait_done(lat);
    chk("hold_lat", 32'(lat), 32'd34);
    hb0 = bus.b0;
    hb1 = bus.b1;
    chk("hold_sum", hb0 ^ hb1, 32'h0000_0000);
    bus.a0 = 32'h5555_5555;
    bus.a1 = 32'h3333_3333;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_b0", bus.b0, hb0);
      chk("hold_b1", bus.b1, hb1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    ack();
    check_idle("hold_ack");

    // Async reset in the middle of RUN.
    start_op(32'hCAFE_BABE, 32'h1357_9BDF);
    repeat (15) tick();
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    chk("rst_mid_cnt", 32'(dut.cnt), 32'd0);
    chk("rst_mid_state", 32'(dut.state), 32'(A2B_IDLE));
    chk("rst_mid_u0", dut.u0, 32'd0);
    chk("rst_mid_v1", dut.v1, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    full_op("after_rst", 32'h8000_0000, 32'h8000_0000);

    // Random regression.
    for (int k = 0; k < 200; k++) begin
      ra = $urandom;
      rb = $urandom;
      full_op("rand", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
